uart_mem_transfer_ctrl: RTL and testbench

Sequencer between the `data_encoder_decoder` word interface and a single-port synchronous data/instruction memory. On command it either stores a run of words received over UART at consecutive addresses, or streams a run of consecutive memory words out through the encoder. It is the host-load and result-dump path of the multicore processor. Receive and transmit share the one memory port, and the block arbitrates between the two commands.

---
 rtl/uart_mem_transfer_ctrl_pkg.sv | 6 +
 rtl/uart_mem_transfer_ctrl_if.sv | 25 ++
 rtl/uart_mem_transfer_ctrl_xfer_counter.sv | 32 +++
 rtl/uart_mem_transfer_ctrl.sv | 92 +++++++++
 tb/tb_uart_mem_transfer_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_transfer_ctrl_pkg.sv
// uart_mem_transfer_ctrl_pkg: controller state type and default widths
package uart_ctrl_pkg;
  localparam int DEFAULT_WORD_SIZE = 24;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, RX_WAIT, TX_READ, TX_LATCH, TX_START, TX_ACK, DONE} ctrl_state_t;
endpackage

// File: rtl/uart_mem_transfer_ctrl_if.sv
// uart_mem_transfer_ctrl_if: encoder/decoder word port plus single-port memory bus
interface uart_mem_transfer_ctrl_if
  import uart_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
  logic rxDone;
  logic [WORD_SIZE-1:0] dataToMem;
  logic txReady;
  logic txStart;
  logic [WORD_SIZE-1:0] dataFromMem;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic memWrEn;
  logic [WORD_SIZE-1:0] memWrData;
  logic [WORD_SIZE-1:0] memRdData;
  modport master (
    input rxDone, dataToMem, txReady, memRdData,
    output txStart, dataFromMem, memAddr, memWrEn, memWrData
  );
  modport slave (
    output rxDone, dataToMem, txReady, memRdData,
    input txStart, dataFromMem, memAddr, memWrEn, memWrData
  );
endinterface

// File: rtl/uart_mem_transfer_ctrl_xfer_counter.sv
// xfer_counter: loadable run address (incrementing, wraps) and remaining-word count
module xfer_counter
  import uart_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  zero,
  output logic                  last
);
  logic [ADDR_WIDTH:0] count;
  // load on an accepted start, then advance one word per step
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      addr <= '0;
      count <= '0;
    end else if (load) begin
      addr <= baseAddr;
      count <= wordCount;
    end else if (step) begin
      addr <= addr + 1'b1;
      count <= count - 1'b1;
    end
  assign zero = count == '0;
  assign last = count == (ADDR_WIDTH+1)'(1);
endmodule

// File: rtl/uart_mem_transfer_ctrl.sv
// uart_mem_transfer_ctrl: UART word <-> memory run sequencer; UART_CTRL_CHECKSUM_EN adds a checksum output
module uart_mem_transfer_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  startRx,
  input  logic                  startTx,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic                  busy,
  output logic                  done,
`ifdef UART_CTRL_CHECKSUM_EN
  output logic [WORD_SIZE-1:0]  checksum,
`endif
  uart_mem_transfer_ctrl_if.master bus
);
  ctrl_state_t state, nextState;
  logic load, step, zero, last, wrAccept;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_SIZE-1:0] wrWord, txWord;

  xfer_counter #(.ADDR_WIDTH(ADDR_WIDTH)) counter (
    .clk(clk), .rstN(rstN), .load(load), .step(step), .baseAddr(baseAddr),
    .wordCount(wordCount), .addr(addr), .zero(zero), .last(last)
  );

  assign wrAccept = state == RX_WAIT && !zero && bus.rxDone;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign bus.txStart = state == TX_START && bus.txReady;
  assign bus.memWrData = wrWord;
  assign bus.dataFromMem = txWord;

  // state register
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) state <= IDLE;
    else state <= nextState;

  // next state and counter control; startRx wins over a simultaneous startTx
  always_comb begin
    nextState = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: begin
        load = startRx || startTx;
        nextState = startRx ? RX_WAIT : startTx ? TX_READ : IDLE;
      end
      RX_WAIT: begin
        step = wrAccept;
        nextState = zero ? DONE : RX_WAIT;
      end
      TX_READ: nextState = zero ? DONE : TX_LATCH;
      TX_LATCH: nextState = TX_START;
      TX_START: nextState = bus.txReady ? TX_ACK : TX_START;
      TX_ACK: begin
        step = !bus.txReady;
        nextState = bus.txReady ? TX_ACK : last ? DONE : TX_READ;
      end
      default: nextState = IDLE;
    endcase
  end

  // memory port and encoder word registers; memAddr leads TX_READ so read data lands in TX_LATCH
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      bus.memWrEn <= 1'b0;
      bus.memAddr <= '0;
      wrWord <= '0;
      txWord <= '0;
    end else begin
      bus.memWrEn <= wrAccept;
      if (wrAccept) wrWord <= bus.dataToMem;
      if (state == TX_LATCH) txWord <= bus.memRdData;
      if (state == IDLE && startTx && !startRx) bus.memAddr <= baseAddr;
      else if (wrAccept) bus.memAddr <= addr;
      else if (state == TX_ACK && step) bus.memAddr <= addr + 1'b1;
    end

`ifdef UART_CTRL_CHECKSUM_EN
  // running sum of words written or sent in the current operation
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) checksum <= '0;
    else if (load) checksum <= '0;
    else if (wrAccept) checksum <= checksum + bus.dataToMem;
    else if (bus.txStart) checksum <= checksum + txWord;
`endif
endmodule

// File: tb/tb_uart_mem_transfer_ctrl.sv
// tb_uart_mem_transfer_ctrl: directed bench with memory and encoder models
module tb_uart_mem_transfer_ctrl;
  localparam int WS = 24;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic startRx = 1'b0;
  logic startTx = 1'b0;
  logic [AW-1:0] baseAddr = '0;
  logic [AW:0] wordCount = '0;
  logic busy, done;
`ifdef UART_CTRL_CHECKSUM_EN
  logic [WS-1:0] checksum;
`endif

  uart_mem_transfer_ctrl_if #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

  uart_mem_transfer_ctrl #(.WORD_SIZE(WS), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rstN(rstN),
    .startRx(startRx),
    .startTx(startTx),
    .baseAddr(baseAddr),
    .wordCount(wordCount),
    .busy(busy),
    .done(done),
`ifdef UART_CTRL_CHECKSUM_EN
    .checksum(checksum),
`endif
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int encCnt = 0;
  int startCyc = 0;
  int badTxStart = 0;
  logic holdOff = 1'b0;
  logic prevBusy = 1'b0;
  logic [WS-1:0] mem [256];
  logic [WS-1:0] words [8];
  int rxCyc [8];
  logic [AW-1:0] wrAddrQ [$];
  logic [WS-1:0] wrDataQ [$];
  logic [WS-1:0] txDataQ [$];
  int wrCycQ [$];
  int txCycQ [$];
  int doneCycQ [$];
  int busyRiseQ [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous single-port memory, read data one cycle after address
  always @(posedge clk) begin
    if (bus.memWrEn === 1'b1) mem[bus.memAddr] <= bus.memWrData;
    bus.memRdData <= mem[bus.memAddr];
  end

  // encoder stays busy for three cycles after each txStart
  always @(posedge clk) encCnt <= encCnt != 0 ? encCnt - 1 : (bus.txStart === 1'b1 ? 3 : 0);
  assign bus.txReady = encCnt == 0 && !holdOff;

  // event log sampled on the falling edge
  always @(negedge clk) begin
    if (bus.memWrEn === 1'b1) begin
      wrAddrQ.push_back(bus.memAddr);
      wrDataQ.push_back(bus.memWrData);
      wrCycQ.push_back(cyc);
    end
    if (bus.txStart === 1'b1) begin
      txDataQ.push_back(bus.dataFromMem);
      txCycQ.push_back(cyc);
      if (bus.txReady !== 1'b1) badTxStart++;
    end
    if (done === 1'b1) doneCycQ.push_back(cyc);
    if (busy === 1'b1 && !prevBusy) busyRiseQ.push_back(cyc);
    prevBusy = busy === 1'b1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    wrAddrQ.delete();
    wrDataQ.delete();
    wrCycQ.delete();
    txDataQ.delete();
    txCycQ.delete();
    doneCycQ.delete();
    busyRiseQ.delete();
  endtask

  task automatic run_rx(input logic [AW-1:0] b, input int n, input int gap);
    startRx = 1'b1;
    baseAddr = b;
    wordCount = (AW+1)'(n);
    startCyc = cyc;
    step;
    startRx = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (gap) step;
      bus.rxDone = 1'b1;
      bus.dataToMem = words[i];
      rxCyc[i] = cyc;
      step;
      bus.rxDone = 1'b0;
    end
    repeat (4) step;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({bus.txStart, bus.memWrEn, busy, done, bus.dataFromMem, bus.memAddr, bus.memWrData} !== '0)
      begin failures++; $display("FAIL reset_outputs: got %h expected 0", {bus.txStart, bus.memWrEn, busy, done, bus.dataFromMem, bus.memAddr, bus.memWrData}); end
    step;
    step;
    rstN = 1'b1;
    step;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_rx;
    clear_log();
    words[0] = 24'hA1B2C3;
    words[1] = 24'h000001;
    words[2] = 24'hFFFFFF;
    run_rx(8'h10, 3, 2);
    checks++;
    if (busyRiseQ.size() != 1 || busyRiseQ[0] != startCyc + 1)
      begin failures++; $display("FAIL rx_busy_rise: got n=%0d cyc=%0d expected cyc=%0d", busyRiseQ.size(), busyRiseQ.size() > 0 ? busyRiseQ[0] : -1, startCyc + 1); end
    checks++;
    if (wrAddrQ.size() != 3) begin failures++; $display("FAIL rx_write_count: got %0d expected 3", wrAddrQ.size()); end
    else for (int i = 0; i < 3; i++) begin
      logic [AW-1:0] ea;
      ea = 8'h10 + 8'(i);
      checks++;
      if (wrAddrQ[i] !== ea || wrDataQ[i] !== words[i] || wrCycQ[i] != rxCyc[i] + 1)
        begin failures++; $display("FAIL rx_write%0d: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d", i, wrAddrQ[i], wrDataQ[i], wrCycQ[i], ea, words[i], rxCyc[i] + 1); end
    end
    checks++;
    if (doneCycQ.size() != 1 || doneCycQ[0] != rxCyc[2] + 2)
      begin failures++; $display("FAIL rx_done: got n=%0d cyc=%0d expected cyc=%0d", doneCycQ.size(), doneCycQ.size() > 0 ? doneCycQ[0] : -1, rxCyc[2] + 2); end
  endtask

  task automatic test_tx;
    int s;
    words[0] = 24'h123456;
    words[1] = 24'hABCDEF;
    run_rx(8'h20, 2, 0);
    clear_log();
    holdOff = 1'b1;
    startTx = 1'b1;
    baseAddr = 8'h20;
    wordCount = 9'd2;
    s = cyc;
    step;
    startTx = 1'b0;
    step;
    bus.rxDone = 1'b1;
    bus.dataToMem = 24'h5A5A5A;
    step;
    bus.rxDone = 1'b0;
    repeat (2) step;
    holdOff = 1'b0;
    repeat (10) step;
    checks++;
    if (txDataQ.size() != 2) begin failures++; $display("FAIL tx_count: got %0d expected 2", txDataQ.size()); end
    else begin
      checks++;
      if (txDataQ[0] !== 24'h123456 || txCycQ[0] != s + 5)
        begin failures++; $display("FAIL tx_word0: got data=%h cyc=%0d expected data=123456 cyc=%0d", txDataQ[0], txCycQ[0], s + 5); end
      checks++;
      if (txDataQ[1] !== 24'hABCDEF || txCycQ[1] != s + 9)
        begin failures++; $display("FAIL tx_word1: got data=%h cyc=%0d expected data=abcdef cyc=%0d", txDataQ[1], txCycQ[1], s + 9); end
    end
    checks++;
    if (badTxStart != 0) begin failures++; $display("FAIL tx_start_while_busy: got %0d expected 0", badTxStart); end
    checks++;
    if (wrAddrQ.size() != 0) begin failures++; $display("FAIL tx_rxdone_ignored: got %0d writes expected 0", wrAddrQ.size()); end
    checks++;
    if (doneCycQ.size() != 1 || doneCycQ[0] != s + 11)
      begin failures++; $display("FAIL tx_done: got n=%0d cyc=%0d expected cyc=%0d", doneCycQ.size(), doneCycQ.size() > 0 ? doneCycQ[0] : -1, s + 11); end
  endtask

  task automatic test_arbitration;
    int r;
    clear_log();
    startRx = 1'b1;
    startTx = 1'b1;
    baseAddr = 8'h30;
    wordCount = 9'd2;
    step;
    startRx = 1'b0;
    startTx = 1'b0;
    step;
    startTx = 1'b1;
    baseAddr = 8'h20;
    step;
    startTx = 1'b0;
    bus.rxDone = 1'b1;
    bus.dataToMem = 24'h111111;
    r = cyc;
    step;
    bus.dataToMem = 24'h222222;
    step;
    bus.rxDone = 1'b0;
    repeat (8) step;
    checks++;
    if (txCycQ.size() != 0) begin failures++; $display("FAIL arb_no_tx: got %0d txStart expected 0", txCycQ.size()); end
    checks++;
    if (wrAddrQ.size() != 2) begin failures++; $display("FAIL arb_write_count: got %0d expected 2", wrAddrQ.size()); end
    else begin
      checks++;
      if (wrAddrQ[0] !== 8'h30 || wrDataQ[0] !== 24'h111111 || wrCycQ[0] != r + 1)
        begin failures++; $display("FAIL arb_write0: got addr=%h data=%h cyc=%0d expected addr=30 data=111111 cyc=%0d", wrAddrQ[0], wrDataQ[0], wrCycQ[0], r + 1); end
      checks++;
      if (wrAddrQ[1] !== 8'h31 || wrDataQ[1] !== 24'h222222 || wrCycQ[1] != r + 2)
        begin failures++; $display("FAIL arb_write1: got addr=%h data=%h cyc=%0d expected addr=31 data=222222 cyc=%0d", wrAddrQ[1], wrDataQ[1], wrCycQ[1], r + 2); end
    end
    checks++;
    if (doneCycQ.size() != 1 || doneCycQ[0] != r + 3 || busyRiseQ.size() != 1)
      begin failures++; $display("FAIL arb_done: got n=%0d cyc=%0d busyRises=%0d expected n=1 cyc=%0d busyRises=1", doneCycQ.size(), doneCycQ.size() > 0 ? doneCycQ[0] : -1, busyRiseQ.size(), r + 3); end
  endtask

  task automatic test_wrap_zero;
    int s;
    logic [AW-1:0] ea [4];
    ea[0] = 8'hFE;
    ea[1] = 8'hFF;
    ea[2] = 8'h00;
    ea[3] = 8'h01;
    clear_log();
    words[0] = 24'h0000FE;
    words[1] = 24'h0000FF;
    words[2] = 24'h100000;
    words[3] = 24'h100001;
    run_rx(8'hFE, 4, 1);
    checks++;
    if (wrAddrQ.size() != 4) begin failures++; $display("FAIL wrap_count: got %0d expected 4", wrAddrQ.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (wrAddrQ[i] !== ea[i] || wrDataQ[i] !== words[i])
        begin failures++; $display("FAIL wrap_write%0d: got addr=%h data=%h expected addr=%h data=%h", i, wrAddrQ[i], wrDataQ[i], ea[i], words[i]); end
    end
    clear_log();
    run_rx(8'h00, 0, 0);
    checks++;
    if (doneCycQ.size() != 1 || doneCycQ[0] != startCyc + 2 || wrAddrQ.size() != 0)
      begin failures++; $display("FAIL zero_rx: got done n=%0d cyc=%0d writes=%0d expected cyc=%0d writes=0", doneCycQ.size(), doneCycQ.size() > 0 ? doneCycQ[0] : -1, wrAddrQ.size(), startCyc + 2); end
    clear_log();
    startTx = 1'b1;
    baseAddr = 8'h20;
    wordCount = 9'd0;
    s = cyc;
    step;
    startTx = 1'b0;
    repeat (5) step;
    checks++;
    if (doneCycQ.size() != 1 || doneCycQ[0] != s + 2 || txCycQ.size() != 0 || wrAddrQ.size() != 0)
      begin failures++; $display("FAIL zero_tx: got done n=%0d cyc=%0d txStarts=%0d writes=%0d expected cyc=%0d none", doneCycQ.size(), doneCycQ.size() > 0 ? doneCycQ[0] : -1, txCycQ.size(), wrAddrQ.size(), s + 2); end
  endtask

  task automatic test_reset_mid_tx;
    for (int i = 0; i < 5; i++) words[i] = 24'h400000 + 24'(i);
    run_rx(8'h40, 5, 0);
    clear_log();
    startTx = 1'b1;
    baseAddr = 8'h40;
    wordCount = 9'd5;
    step;
    startTx = 1'b0;
    for (int i = 0; i < 60 && txCycQ.size() < 2; i++) step;
    checks++;
    if (txCycQ.size() < 2) begin failures++; $display("FAIL midtx_timeout: got %0d txStart expected 2", txCycQ.size()); end
    rstN = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.txStart, bus.memWrEn, busy, done, bus.dataFromMem, bus.memAddr, bus.memWrData} !== '0)
      begin failures++; $display("FAIL midtx_reset_outputs: got %h expected 0", {bus.txStart, bus.memWrEn, busy, done, bus.dataFromMem, bus.memAddr, bus.memWrData}); end
    step;
    rstN = 1'b1;
    step;
    clear_log();
    startTx = 1'b1;
    baseAddr = 8'h20;
    wordCount = 9'd2;
    step;
    startTx = 1'b0;
    repeat (20) step;
    checks++;
    if (txDataQ.size() != 2 || txDataQ[0] !== 24'h123456 || txDataQ[1] !== 24'hABCDEF || doneCycQ.size() != 1)
      begin failures++; $display("FAIL midtx_restart: got n=%0d d0=%h d1=%h dones=%0d expected n=2 d0=123456 d1=abcdef dones=1", txDataQ.size(), txDataQ.size() > 0 ? txDataQ[0] : 24'h0, txDataQ.size() > 1 ? txDataQ[1] : 24'h0, doneCycQ.size()); end
    checks++;
    if (badTxStart != 0) begin failures++; $display("FAIL start_while_busy_total: got %0d expected 0", badTxStart); end
  endtask

`ifdef UART_CTRL_CHECKSUM_EN
  task automatic test_checksum;
    startRx = 1'b1;
    baseAddr = 8'h50;
    wordCount = 9'd2;
    step;
    startRx = 1'b0;
    bus.rxDone = 1'b1;
    bus.dataToMem = 24'hFFFFFF;
    step;
    bus.dataToMem = 24'h000002;
    step;
    bus.rxDone = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) step;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL checksum_done_timeout: got %b expected 1", done); end
    checks++;
    if (checksum !== 24'h000001) begin failures++; $display("FAIL checksum_rx: got %h expected 000001", checksum); end
    repeat (3) step;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxDone = 1'b0;
    bus.dataToMem = '0;
    test_reset();
    test_rx();
    test_tx();
    test_arbitration();
    test_wrap_zero();
    test_reset_mid_tx();
`ifdef UART_CTRL_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
